bfly_sdf_i: RTL and testbench

BFLY_SDF_I -- requirements
Module: bfly_sdf_i

---
 rtl/bfly_sdf_i.sv | 93 +++++++++
 tb/tb_bfly_sdf_i.sv | 114 +++++++++++
 2 files changed

// File: rtl/bfly_sdf_i.sv
// bfly_sdf_i: radix-2 single-path delay-feedback butterfly stage with scaled sum/difference and a flush mode
module bfly_sdf_i #(
  parameter int FFT_STG       = 12,
  parameter int TOTAL_STAGE_P = 12,
  parameter int MULT_WIDTH_P  = 18
) (
  input  logic                        iclk,
  input  logic                        irst,
  input  logic                        ien,
  input  logic                        iflush,
  input  logic [TOTAL_STAGE_P-1:0]    iaddr,
  input  logic [2*MULT_WIDTH_P-1:0]   idata,
  output logic                        oen,
  output logic [TOTAL_STAGE_P-1:0]    oaddr,
  output logic [2*MULT_WIDTH_P-1:0]   odata,
  output logic                        obusy
);
  localparam int W  = MULT_WIDTH_P;
  localparam int D  = 1 << (FFT_STG - 1);
  localparam int CW = FFT_STG - 1;
  localparam logic [TOTAL_STAGE_P-1:0] HBIT    = TOTAL_STAGE_P'(D);
  localparam logic [TOTAL_STAGE_P-1:0] LO_MASK = TOTAL_STAGE_P'(2 * D - 1);
  typedef enum logic {NORM, FLUSH} state_t;
  state_t                     state_q;
  logic [CW-1:0]              flush_cnt_q;
  logic [TOTAL_STAGE_P-1:0]   last_iaddr_q;
  logic [D-1:0]               tag_q;
  logic [2*W-1:0]             data_q [D];
  logic                       oen_q;
  logic [TOTAL_STAGE_P-1:0]   oaddr_q;
  logic [2*W-1:0]             odata_q;
  logic [2*W-1:0]             tail, sum, dif, push_data;
  logic                       accept, half, shift, push_tag;
  // widen by one bit so the sum/difference never overflows before halving
  function automatic logic [W-1:0] half_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] ae, be, s;
    ae = {a[W-1], a};
    be = {b[W-1], b};
    s  = sub ? ae - be : ae + be;
    return W'($signed(s) >>> 1);
  endfunction
  always_comb begin
    tail      = data_q[D-1];
    half      = iaddr[FFT_STG-1];
    accept    = state_q == NORM && ien;
    shift     = accept || state_q == FLUSH;
    sum       = {half_op(tail[2*W-1:W], idata[2*W-1:W], 1'b0), half_op(tail[W-1:0], idata[W-1:0], 1'b0)};
    dif       = {half_op(tail[2*W-1:W], idata[2*W-1:W], 1'b1), half_op(tail[W-1:0], idata[W-1:0], 1'b1)};
    push_tag  = accept && half;
    push_data = !accept ? '0 : half ? dif : idata;
  end
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q      <= NORM;
      flush_cnt_q  <= '0;
      last_iaddr_q <= '0;
      tag_q        <= '0;
      for (int i = 0; i < D; i++) data_q[i] <= '0;
      oen_q        <= 1'b0;
      oaddr_q      <= '0;
      odata_q      <= '0;
    end else begin
      if (shift) begin
        tag_q     <= {tag_q[D-2:0], push_tag};
        for (int i = D - 1; i > 0; i--) data_q[i] <= data_q[i-1];
        data_q[0] <= push_data;
      end
      if (accept) begin
        oen_q        <= half | tag_q[D-1];
        odata_q      <= half ? sum : tail;
        oaddr_q      <= iaddr ^ HBIT;
        last_iaddr_q <= iaddr;
      end else if (state_q == FLUSH) begin
        oen_q   <= tag_q[D-1];
        odata_q <= tail;
        oaddr_q <= (last_iaddr_q & ~LO_MASK) | HBIT | TOTAL_STAGE_P'(flush_cnt_q);
      end else begin
        oen_q <= 1'b0;
      end
      if (state_q == NORM && iflush) begin
        state_q     <= FLUSH;
        flush_cnt_q <= '0;
      end else if (state_q == FLUSH) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
        if (flush_cnt_q == CW'(D - 1)) state_q <= NORM;
      end
    end
  end
  assign oen   = oen_q;
  assign oaddr = oaddr_q;
  assign odata = odata_q;
  assign obusy = state_q == FLUSH;
endmodule

// File: tb/tb_bfly_sdf_i.sv
// tb_bfly_sdf_i: directed checks of the D=2 butterfly stage with hand-computed expectations
module tb_bfly_sdf_i;
  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        ien = 1'b0;
  logic        iflush = 1'b0;
  logic [3:0]  iaddr = '0;
  logic [35:0] idata = '0;
  logic        oen;
  logic [3:0]  oaddr;
  logic [35:0] odata;
  logic        obusy;
  int n_cmp = 0;
  int n_err = 0;

  bfly_sdf_i #(.FFT_STG(2), .TOTAL_STAGE_P(4), .MULT_WIDTH_P(18)) dut (
    .iclk(iclk), .irst(irst), .ien(ien), .iflush(iflush), .iaddr(iaddr),
    .idata(idata), .oen(oen), .oaddr(oaddr), .odata(odata), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  function automatic logic [35:0] pk(input int re, input int im);
    return {18'(re), 18'(im)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic fl, input logic [3:0] a, input int re, input int im);
    @(negedge iclk);
    ien = en; iflush = fl; iaddr = a; idata = pk(re, im);
    @(posedge iclk);
    #1;
  endtask

  task automatic out(input string tag, input logic [3:0] a, input int re, input int im);
    chk({tag, ".oen"}, 64'(oen), 64'(1'b1));
    chk({tag, ".oaddr"}, 64'(oaddr), 64'(a));
    chk({tag, ".odata"}, 64'(odata), 64'(pk(re, im)));
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge iclk);
    #1;
    chk("rst.oen", 64'(oen), 0); chk("rst.oaddr", 64'(oaddr), 0);
    chk("rst.odata", 64'(odata), 0); chk("rst.obusy", 64'(obusy), 0);
    @(negedge iclk); irst = 1'b0;
    // basic block 100,200,300,500
    step(1, 0, 0, 100, 0); chk("b0.oen0", 64'(oen), 0);
    step(1, 0, 1, 200, 0); chk("b0.oen1", 64'(oen), 0);
    step(1, 0, 2, 300, 0); out("b0.s0", 0, 200, 0);
    step(1, 0, 3, 500, 0); out("b0.s1", 1, 350, 0);
    step(0, 1, 0, 0, 0);   chk("fl0.busy", 64'(obusy), 1); chk("fl0.oen", 64'(oen), 0);
    step(0, 0, 0, 0, 0);   out("fl0.d0", 2, -100, 0); chk("fl0.busy2", 64'(obusy), 1);
    step(0, 0, 0, 0, 0);   out("fl0.d1", 3, -150, 0); chk("fl0.busy3", 64'(obusy), 0);
    step(0, 0, 0, 0, 0);   chk("idle.oen", 64'(oen), 0);
    chk("idle.hold", 64'(odata), 64'(pk(-150, 0)));
    // back-to-back blocks A (4..7) then B (8..11)
    step(1, 0, 4, 10, 2);  chk("a.oen0", 64'(oen), 0);
    step(1, 0, 5, 20, 4);  chk("a.oen1", 64'(oen), 0);
    step(1, 0, 6, 30, 6);  out("a.s0", 4, 20, 4);
    step(1, 0, 7, 40, 8);  out("a.s1", 5, 30, 6);
    step(1, 0, 8, 1, 0);   out("b.d0", 10, -10, -2);
    step(1, 0, 9, 3, 0);   out("b.d1", 11, -10, -2);
    step(1, 0, 10, 5, 0);  out("b.s0", 8, 3, 0);
    step(1, 0, 11, -7, 0); out("b.s1", 9, -2, 0);
    // block C with ien toggling
    step(1, 0, 12, 2, 0);  out("c.d0", 14, -2, 0);
    step(0, 0, 0, 77, 77); chk("c.gap0", 64'(oen), 0); chk("c.hold0", 64'(oaddr), 14);
    step(1, 0, 13, 4, 0);  out("c.d1", 15, 5, 0);
    step(0, 0, 0, 77, 77); chk("c.gap1", 64'(oen), 0);
    step(1, 0, 14, 6, 0);  out("c.s0", 12, 4, 0);
    step(0, 0, 0, 77, 77); chk("c.gap2", 64'(oen), 0);
    step(1, 0, 15, 8, 0);  out("c.s1", 13, 6, 0);
    // flush with ien=1 junk that must be dropped
    step(0, 1, 0, 0, 0);   chk("fl1.busy", 64'(obusy), 1);
    step(1, 0, 0, 999, 9); out("fl1.d0", 14, -2, 0);
    step(1, 0, 1, 888, 8); out("fl1.d1", 15, -2, 0); chk("fl1.end", 64'(obusy), 0);
    step(0, 0, 0, 0, 0);   chk("fl1.idle", 64'(oen), 0);
    // floor rounding, then flush coincident with the last sample
    step(1, 0, 0, -3, 7);  chk("r.oen0", 64'(oen), 0);
    step(1, 0, 1, 0, 0);   chk("r.oen1", 64'(oen), 0);
    step(1, 0, 2, 0, 0);   out("r.s0", 0, -2, 3);
    step(1, 1, 3, 0, 0);   out("r.s1", 1, 0, 0); chk("r.busy", 64'(obusy), 1);
    step(0, 0, 0, 0, 0);   out("r.d0", 2, -2, 3);
    step(0, 0, 0, 0, 0);   out("r.d1", 3, 0, 0);
    // reset pulsed in the second flush cycle
    step(1, 0, 0, 100, 0);
    step(1, 0, 1, 200, 0);
    step(1, 0, 2, 300, 0);
    step(1, 0, 3, 500, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);   out("x.d0", 2, -100, 0);
    @(negedge iclk); irst = 1'b1; ien = 1'b0; iflush = 1'b0;
    #1;
    chk("x.oen", 64'(oen), 0); chk("x.oaddr", 64'(oaddr), 0);
    chk("x.odata", 64'(odata), 0); chk("x.busy", 64'(obusy), 0);
    @(negedge iclk); irst = 1'b0;
    step(0, 1, 0, 0, 0);   chk("y.busy", 64'(obusy), 1);
    step(0, 0, 0, 0, 0);   chk("y.oen0", 64'(oen), 0);
    step(0, 0, 0, 0, 0);   chk("y.oen1", 64'(oen), 0); chk("y.end", 64'(obusy), 0);
    step(1, 0, 0, 5, 5);   chk("y.blk0", 64'(oen), 0);
    step(1, 0, 1, 6, 6);   chk("y.blk1", 64'(oen), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
